// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with byte/half/word access and lane steering.
// Optional round-robin tie-breaking is enabled by defining DMEM_ARB_ROUND_ROBIN_EN.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int WORD_AW = 17
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               p0_valid,
    output logic               p0_ready,
    input  logic               p0_we,
    input  logic [1:0]         p0_size,
    input  logic               p0_uns,
    input  logic [ADDR_W-1:0]  p0_addr,
    input  logic [31:0]        p0_wdata,
    output logic               p0_rvalid,
    output logic [31:0]        p0_rdata,
    output logic               p0_err,

    input  logic               p1_valid,
    output logic               p1_ready,
    input  logic               p1_we,
    input  logic [1:0]         p1_size,
    input  logic               p1_uns,
    input  logic [ADDR_W-1:0]  p1_addr,
    input  logic [31:0]        p1_wdata,
    output logic               p1_rvalid,
    output logic [31:0]        p1_rdata,
    output logic               p1_err,

    output logic [WORD_AW-1:0] mem_widx,
    output logic               mem_we,
    output logic [3:0]         mem_be,
    output logic [31:0]        mem_wdata,
    input  logic [31:0]        mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state, state_next;

    logic               grant0, grant1, accept;
    logic               port_q, we_q, uns_q, err_q;
    logic [1:0]         size_q;
    logic [WORD_AW+1:0] addr_q;
    logic [31:0]        wdata_q;
    logic [1:0]         off;
    logic               misalign;
    logic [3:0]         be_lanes;
    logic [31:0]        shifted, load_data, resp_data;

    // Only the word-index bits of the address reach memory.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{p0_addr[ADDR_W-1:WORD_AW+2], p1_addr[ADDR_W-1:WORD_AW+2]};

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic last_q;

    // last_q holds the most recently granted port; it starts at 1 so port 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= 1'b1;
        else if (accept)
            last_q <= grant1;
    end

    always_comb begin
        grant0 = p0_valid;
        grant1 = p1_valid;
        if (p0_valid && p1_valid) begin
            grant0 = last_q;
            grant1 = !last_q;
        end
    end
`else
    always_comb begin
        grant0 = p0_valid;
        grant1 = p1_valid && !p0_valid;
    end
`endif

    assign accept   = (state == IDLE) && (grant0 || grant1);
    assign p0_ready = (state == IDLE) && grant0 && !rst;
    assign p1_ready = (state == IDLE) && grant1 && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            port_q  <= 1'b0;
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            port_q  <= grant1;
            we_q    <= grant1 ? p1_we    : p0_we;
            size_q  <= grant1 ? p1_size  : p0_size;
            uns_q   <= grant1 ? p1_uns   : p0_uns;
            addr_q  <= grant1 ? p1_addr[WORD_AW+1:0] : p0_addr[WORD_AW+1:0];
            wdata_q <= grant1 ? p1_wdata : p0_wdata;
        end
    end

    assign off      = addr_q[1:0];
    assign misalign = (size_q == 2'd3) ||
                      (size_q == 2'd1 && off[0]) ||
                      (size_q == 2'd2 && off != 2'd0);

    always_comb begin
        be_lanes = 4'h0;
        case (size_q)
            2'd0:    be_lanes = 4'b0001 << off;
            2'd1:    be_lanes = 4'b0011 << off;
            2'd2:    be_lanes = 4'hF;
            default: be_lanes = 4'h0;
        endcase
    end

    // Misaligned requests still present their word index but never enable a lane.
    always_comb begin
        mem_widx  = '0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_wdata = '0;
        if (state == ACCESS) begin
            mem_widx = addr_q[WORD_AW+1:2];
            if (!misalign) begin
                mem_we    = we_q;
                mem_be    = be_lanes;
                mem_wdata = wdata_q << {off, 3'b000};
            end
        end
    end

    always_comb begin
        shifted   = mem_rdata >> {off, 3'b000};
        load_data = mem_rdata;
        case (size_q)
            2'd0:    load_data = uns_q ? {24'd0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'd1:    load_data = uns_q ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_data = mem_rdata;
        endcase
        resp_data = (misalign || we_q) ? 32'd0 : load_data;
    end

    // Each port's rdata register only changes when that port's response is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q    <= 1'b0;
            p0_rdata <= '0;
            p1_rdata <= '0;
        end else if (state == ACCESS) begin
            err_q <= misalign;
            if (port_q)
                p1_rdata <= resp_data;
            else
                p0_rdata <= resp_data;
        end
    end

    assign p0_rvalid = (state == RESP) && !port_q;
    assign p1_rvalid = (state == RESP) && port_q;
    assign p0_err    = p0_rvalid && err_q;
    assign p1_err    = p1_rvalid && err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a byte-level shadow memory predicts every response.
module tb_dmem_arbiter;

    localparam int ADDR_W  = 32;
    localparam int WORD_AW = 17;

    logic               clk, rst;
    logic               p0_valid, p0_ready, p0_we, p0_uns, p0_rvalid, p0_err;
    logic [1:0]         p0_size;
    logic [ADDR_W-1:0]  p0_addr;
    logic [31:0]        p0_wdata, p0_rdata;
    logic               p1_valid, p1_ready, p1_we, p1_uns, p1_rvalid, p1_err;
    logic [1:0]         p1_size;
    logic [ADDR_W-1:0]  p1_addr;
    logic [31:0]        p1_wdata, p1_rdata;
    logic [WORD_AW-1:0] mem_widx;
    logic               mem_we;
    logic [3:0]         mem_be;
    logic [31:0]        mem_wdata, mem_rdata;

    dmem_arbiter #(.ADDR_W(ADDR_W), .WORD_AW(WORD_AW)) dut (
        .clk(clk), .rst(rst),
        .p0_valid(p0_valid), .p0_ready(p0_ready), .p0_we(p0_we), .p0_size(p0_size),
        .p0_uns(p0_uns), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_valid(p1_valid), .p1_ready(p1_ready), .p1_we(p1_we), .p1_size(p1_size),
        .p1_uns(p1_uns), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .mem_widx(mem_widx), .mem_we(mem_we), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory attached to the DUT; addresses used by the bench stay below 4 KiB.
    logic [31:0] mem [0:1023] = '{default: 32'd0};
    always_comb mem_rdata = mem[10'(mem_widx)];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (mem_we && mem_be[i])
                mem[10'(mem_widx)][8*i +: 8] <= mem_wdata[8*i +: 8];
    end

    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } resp_t;

    logic [7:0] sb [0:4095];
    resp_t      q0[$], q1[$];
    int         g_port[$], g_cyc[$];
    int         checks = 0, errors = 0, cyc = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic is_bad(input logic [1:0] size, input logic [31:0] addr);
        return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0);
    endfunction

    // Reference: a byte-addressed memory; loads gather bytes, stores scatter them.
    task automatic modelAccept(input int port, input logic we, input logic [1:0] size,
                               input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        resp_t r;
        int a;
        logic [15:0] h;
        a = int'(addr & 32'hFFF);
        r.data = 32'd0;
        r.err  = 1'b0;
        if (is_bad(size, addr)) begin
            r.err = 1'b1;
        end else if (we) begin
            for (int i = 0; i < (1 << size); i++)
                sb[a + i] = wdata[8*i +: 8];
        end else if (size == 2'd0) begin
            r.data = uns ? {24'd0, sb[a]} : {{24{sb[a][7]}}, sb[a]};
        end else if (size == 2'd1) begin
            h = {sb[a + 1], sb[a]};
            r.data = uns ? {16'd0, h} : {{16{h[15]}}, h};
        end else begin
            r.data = {sb[a + 3], sb[a + 2], sb[a + 1], sb[a]};
        end
        if (port == 0) q0.push_back(r);
        else           q1.push_back(r);
    endtask

    // Acceptance monitor feeds the scoreboard and logs grants.
    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (p0_valid && p0_ready) begin
                modelAccept(0, p0_we, p0_size, p0_uns, p0_addr, p0_wdata);
                g_port.push_back(0);
                g_cyc.push_back(cyc);
            end
            if (p1_valid && p1_ready) begin
                modelAccept(1, p1_we, p1_size, p1_uns, p1_addr, p1_wdata);
                g_port.push_back(1);
                g_cyc.push_back(cyc);
            end
            if (p0_ready && p1_ready)
                checkOutput("both_ready", 32'd1, 32'd0);
        end
    end

    // Response monitor compares every strobe against the oldest expectation for that port.
    always @(negedge clk) begin
        resp_t e;
        if (!rst) begin
            if (p0_rvalid) begin
                if (q0.size() == 0) begin
                    checkOutput("p0_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = q0.pop_front();
                    checkOutput("p0_rdata", p0_rdata, e.data);
                    checkOutput("p0_err", {31'd0, p0_err}, {31'd0, e.err});
                end
            end
            if (p1_rvalid) begin
                if (q1.size() == 0) begin
                    checkOutput("p1_unexpected_rvalid", 32'd1, 32'd0);
                end else begin
                    e = q1.pop_front();
                    checkOutput("p1_rdata", p1_rdata, e.data);
                    checkOutput("p1_err", {31'd0, p1_err}, {31'd0, e.err});
                end
            end
        end
    end

    task automatic drivePort(input int port, input logic valid, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        if (port == 0) begin
            p0_valid = valid; p0_we = we; p0_size = size; p0_uns = uns; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_valid = valid; p1_we = we; p1_size = size; p1_uns = uns; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    // One request on one port: waits for acceptance, then checks ACCESS lanes and response timing.
    task automatic applyStimulus(input int port, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
        logic       got, rdy;
        logic [3:0] exp_be;
        @(posedge clk);
        #2 drivePort(port, 1'b1, we, size, uns, addr, wdata);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            rdy = (port == 0) ? p0_ready : p1_ready;
            if (rdy) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checkOutput("ready_timeout", 32'd0, 32'd1);
            drivePort(port, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
            return;
        end
        @(posedge clk);
        #2 drivePort(port, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        exp_be = 4'h0;
        if (!is_bad(size, addr))
            exp_be = (size == 2'd0) ? 4'b0001 << addr[1:0] :
                     (size == 2'd1) ? 4'b0011 << addr[1:0] : 4'hF;
        @(negedge clk);
        checkOutput("access_be", {28'd0, mem_be}, {28'd0, exp_be});
        checkOutput("access_we", {31'd0, mem_we}, {31'd0, we && !is_bad(size, addr)});
        checkOutput("access_widx", {15'd0, mem_widx}, addr >> 2);
        @(negedge clk);
        checkOutput("rvalid_latency", {31'd0, (port == 0) ? p0_rvalid : p1_rvalid}, 32'd1);
        checkOutput("other_rvalid", {31'd0, (port == 0) ? p1_rvalid : p0_rvalid}, 32'd0);
    endtask

    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [7:0]  saved [0:3];
    int          r_port, p1_grants;

    initial begin
        for (int i = 0; i < 4096; i++) sb[i] = 8'd0;
        rst = 1'b1;
        drivePort(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        drivePort(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        #1 p0_valid = 1'b1;
        p1_valid = 1'b1;
        @(negedge clk);
        checkOutput("reset_ready", {30'd0, p0_ready, p1_ready}, 32'd0);
        checkOutput("reset_rvalid_err", {28'd0, p0_rvalid, p1_rvalid, p0_err, p1_err}, 32'd0);
        checkOutput("reset_mem_ctl", {27'd0, mem_we, mem_be}, 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset_mem_widx", {15'd0, mem_widx}, 32'd0);
        checkOutput("reset_rdata", p0_rdata | p1_rdata, 32'd0);
        @(posedge clk);
        #2 p0_valid = 1'b0;
        p1_valid = 1'b0;
        rst = 1'b0;

        applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        checkOutput("p0_word_load_held", p0_rdata, 32'hDEADBEEF);
        applyStimulus(0, 1'b1, 2'd0, 1'b0, 32'h103, 32'h00000080);
        applyStimulus(0, 1'b0, 2'd0, 1'b0, 32'h103, 32'h0);
        checkOutput("byte_signed", p0_rdata, 32'hFFFFFF80);
        applyStimulus(0, 1'b0, 2'd0, 1'b1, 32'h103, 32'h0);
        checkOutput("byte_unsigned", p0_rdata, 32'h00000080);
        applyStimulus(0, 1'b1, 2'd1, 1'b0, 32'h101, 32'h0000AAAA);
        checkOutput("misaligned_mem_unchanged", mem[64], 32'h80ADBEEF);
        applyStimulus(0, 1'b1, 2'd2, 1'b0, 32'h200, 32'h12345678);
        applyStimulus(1, 1'b0, 2'd1, 1'b0, 32'h202, 32'h0);
        checkOutput("p1_half_held", p1_rdata, 32'h00001234);

        // Reset in the ACCESS cycle of a store.
        for (int i = 0; i < 4; i++) saved[i] = sb[32'h300 + i];
        @(posedge clk);
        #2 drivePort(0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFEF00D);
        @(negedge clk);
        checkOutput("rst_test_ready", {31'd0, p0_ready}, 32'd1);
        @(posedge clk);
        #2 drivePort(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        #1 checkOutput("rst_test_access_we", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("rst_abort_mem", {27'd0, mem_we, mem_be}, 32'd0);
        checkOutput("rst_abort_wdata_widx", mem_wdata | {15'd0, mem_widx}, 32'd0);
        checkOutput("rst_abort_resp", {28'd0, p0_rvalid, p1_rvalid, p0_ready, p1_ready}, 32'd0);
        checkOutput("rst_abort_rdata", p0_rdata | p1_rdata, 32'd0);
        for (int i = 0; i < 4; i++) sb[32'h300 + i] = saved[i];
        q0.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        checkOutput("rst_no_write", mem[192], {saved[3], saved[2], saved[1], saved[0]});
        repeat (4) @(posedge clk);

        // Both ports requesting continuously from a fresh reset.
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        g_port.delete();
        g_cyc.delete();
        drivePort(0, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        drivePort(1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0);
        repeat (13) @(posedge clk);
        #2 drivePort(0, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        drivePort(1, 1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
        repeat (4) @(posedge clk);
        if (g_port.size() < 4) begin
            checkOutput("arb_grant_count", g_port.size(), 32'd4);
        end else begin
            p1_grants = 0;
            for (int i = 0; i < g_port.size(); i++) p1_grants += g_port[i];
            for (int i = 0; i < 4; i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                checkOutput($sformatf("arb_grant_%0d", i), g_port[i], i % 2);
`else
                checkOutput($sformatf("arb_grant_%0d", i), g_port[i], 0);
`endif
                if (i > 0)
                    checkOutput($sformatf("arb_gap_%0d", i), g_cyc[i] - g_cyc[i-1], 3);
            end
`ifndef DMEM_ARB_ROUND_ROBIN_EN
            checkOutput("arb_p1_starved", p1_grants, 0);
`endif
        end

        for (int n = 0; n < 40; n++) begin
            r_port = int'($urandom_range(0, 1));
            r_we   = 1'($urandom_range(0, 1));
            r_uns  = 1'($urandom_range(0, 1));
            r_size = 2'($urandom_range(0, 3));
            r_addr = $urandom_range(0, 4095);
            if ($urandom_range(0, 3) != 0) begin
                if (r_size == 2'd1) r_addr = r_addr & ~32'd1;
                if (r_size == 2'd2) r_addr = r_addr & ~32'd3;
            end
            applyStimulus(r_port, r_we, r_size, r_uns, r_addr, $urandom);
        end

        repeat (3) @(posedge clk);
        checkOutput("q0_drained", q0.size(), 32'd0);
        checkOutput("q1_drained", q1.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
